// File: rtl/pcpi_mac_pkg.sv
// pcpi_mac shared constants: custom-0 opcode, funct7 tag,
// funct3 operation codes and the control FSM state encoding.
package pcpi_mac_pkg;

  localparam logic [6:0] CUSTOM0 = 7'b0001011;
  localparam logic [6:0] MAC_F7  = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULHU  = 3'b001,
    F3_MAC    = 3'b010,
    F3_ACCLO  = 3'b011,
    F3_ACCHI  = 3'b100,
    F3_ACCCLR = 3'b101
  } funct3_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/pcpi_mac_iter_mul.sv
// Iterative unsigned 32x32 shift-add multiplier, RADIX_BITS per cycle.
// Ports: pcpi_clock, pcpi_reset (async high), start, a, b -> done, p.
module pcpi_mac_iter_mul #(
  parameter int RADIX_BITS = 2
) (
  input  logic        pcpi_clock,
  input  logic        pcpi_reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] p
);

  localparam int N = 32 / RADIX_BITS;

  logic [63:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] p_q, p_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] part;

  assign part = a_q * {{(64-RADIX_BITS){1'b0}},
                       b_q[RADIX_BITS-1:0]};

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    if (start) begin
      a_d   = {32'd0, a};
      b_d   = b;
      p_d   = '0;
      cnt_d = 6'(N);
    end else if (cnt_q != 6'd0) begin
      p_d   = p_q + part;
      a_d   = a_q << RADIX_BITS;
      b_d   = b_q >> RADIX_BITS;
      cnt_d = cnt_q - 6'd1;
    end
  end

  // done fires in the last iteration cycle; p then shows the
  // finished product so the caller can use it at that same edge.
  assign done = (cnt_q == 6'd1) && !start;
  assign p    = p_d;

  always_ff @(posedge pcpi_clock or posedge pcpi_reset) begin
    if (pcpi_reset) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pcpi_mac.sv
// PCPI multiply / multiply-accumulate co-processor (custom-0).
// Ports: pcpi_clock/reset, valid/insn/rs1/rs2 in; wr/rd/wait/ready out.
module pcpi_mac
  import pcpi_mac_pkg::*;
#(
  parameter int RADIX_BITS = 2,
  parameter int ACC_WIDTH  = 64
) (
  input  logic        pcpi_clock,
  input  logic        pcpi_reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  state_t state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [31:0]          rd_q, rd_d;
  logic                 wait_q, wait_d;
  logic                 ready_q, ready_d;

  logic [2:0]  f3;
  logic        claim;
  logic        is_mul;
  logic        mul_start;
  logic        mul_done;
  logic [63:0] mul_p;
  logic        unused_insn;

  assign f3 = pcpi_insn[14:12];
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // funct3 110/111 are left for the CPU to trap on
  assign claim = pcpi_valid
              && pcpi_insn[6:0] == CUSTOM0
              && pcpi_insn[31:25] == MAC_F7
              && !(f3[2] && f3[1]);

  assign is_mul = !f3[2] && !(f3[1] && f3[0]);

  assign mul_start = (state_q == S_IDLE) && claim && is_mul;

  pcpi_mac_iter_mul #(
    .RADIX_BITS (RADIX_BITS)
  ) u_mul (
    .pcpi_clock (pcpi_clock),
    .pcpi_reset (pcpi_reset),
    .start      (mul_start),
    .a          (pcpi_rs1),
    .b          (pcpi_rs2),
    .done       (mul_done),
    .p          (mul_p)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    rd_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (claim) begin
          op_d = f3;
          if (is_mul) begin
            state_d = S_BUSY;
          end else begin
            state_d = S_RESP;
            unique case (f3)
              F3_ACCLO: rd_d = acc_q[31:0];
              F3_ACCHI: rd_d = acc_q[63:32];
              default:  acc_d = '0;
            endcase
          end
        end
      end
      S_BUSY: begin
        // a dropped valid is a CPU abort: no response, acc untouched
        if (!pcpi_valid) begin
          state_d = S_IDLE;
        end else if (mul_done) begin
          state_d = S_RESP;
          unique case (op_q)
            F3_MULHU: rd_d = mul_p[63:32];
            F3_MAC: begin
              acc_d = acc_q + mul_p;
              rd_d  = acc_q[31:0] + mul_p[31:0];
            end
            default:  rd_d = mul_p[31:0];
          endcase
        end
      end
      S_RESP: state_d = S_HOLD;
      S_HOLD: begin
        // wait for the CPU to retire the instruction
        if (!pcpi_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wait_d  = (state_d == S_BUSY);
  assign ready_d = (state_d == S_RESP);

  always_ff @(posedge pcpi_clock or posedge pcpi_reset) begin
    if (pcpi_reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      rd_q    <= '0;
      wait_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      rd_q    <= rd_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
    end
  end

  assign pcpi_rd    = rd_q;
  assign pcpi_wr    = ready_q;
  assign pcpi_ready = ready_q;
  assign pcpi_wait  = wait_q;

endmodule

// File: tb/tb_pcpi_mac.sv
// Directed self-checking bench for pcpi_mac.
// Drives on negedge, samples on negedge (cycle k = k-th negedge).
module tb_pcpi_mac;

  localparam int RB   = 2;
  localparam int MCYC = 32 / RB + 1;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [31:0] insn;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        wr;
  logic [31:0] rd;
  logic        wt;
  logic        rdy;

  int checks   = 0;
  int failures = 0;

  pcpi_mac #(
    .RADIX_BITS (RB),
    .ACC_WIDTH  (64)
  ) dut (
    .pcpi_clock (clk),
    .pcpi_reset (rst),
    .pcpi_valid (valid),
    .pcpi_insn  (insn),
    .pcpi_rs1   (rs1),
    .pcpi_rs2   (rs2),
    .pcpi_wr    (wr),
    .pcpi_rd    (rd),
    .pcpi_wait  (wt),
    .pcpi_ready (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {7'h01, 10'd0, f3, 5'd0, 7'h0B};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag,
                    input logic [2:0] f3,
                    input logic [31:0] a,
                    input logic [31:0] b,
                    input logic [31:0] erd,
                    input int ecyc);
    int rc;
    int wbad;
    logic [31:0] r;
    logic w;
    @(negedge clk);
    insn  = mk(f3);
    rs1   = a;
    rs2   = b;
    valid = 1'b1;
    rc    = -1;
    wbad  = 0;
    r     = '0;
    w     = 1'b0;
    for (int k = 1; k <= 40 && rc < 0; k++) begin
      @(negedge clk);
      if (k == 3) begin
        rs1 = ~a;
        rs2 = ~b;
      end
      if (wt !== (k < ecyc)) wbad++;
      if (rdy === 1'b1) begin
        rc = k;
        r  = rd;
        w  = wr;
      end
    end
    valid = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, ".rd"}, 64'(r), 64'(erd));
    chk({tag, ".wr"}, 64'(w), 64'd1);
    chk({tag, ".cyc"}, 64'(rc), 64'(ecyc));
    chk({tag, ".wait"}, 64'(wbad), 64'd0);
  endtask

  task automatic unclaimed(input string tag,
                           input logic [31:0] iw);
    int bad;
    bad = 0;
    @(negedge clk);
    insn  = iw;
    rs1   = 32'h1234_5678;
    rs2   = 32'h9;
    valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wt !== 1'b0 || rdy !== 1'b0) bad++;
    end
    valid = 1'b0;
    @(negedge clk);
    chk(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    int cnt;
    int rc;
    logic [31:0] r;

    rst   = 1'b1;
    valid = 1'b0;
    insn  = '0;
    rs1   = '0;
    rs2   = '0;
    repeat (2) @(negedge clk);
    chk("rst.out", {wt, rdy, wr, rd}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.out", {wt, rdy, wr, rd}, '0);
    op("accinit", 3'b011, 0, 0, 32'h0, 1);

    op("mul", 3'b000, 32'h0001_0003, 32'h5, 32'h0005_000F, MCYC);
    op("mulhu", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
       32'hFFFF_FFFE, MCYC);
    op("mul2", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
       32'h0000_0001, MCYC);

    op("clr", 3'b101, 0, 0, 32'h0, 1);
    op("mac1", 3'b010, 32'd3, 32'd4, 32'd12, MCYC);
    op("mac2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hA, MCYC);
    op("acchi", 3'b100, 0, 0, 32'h2, 1);
    op("acclo", 3'b011, 0, 0, 32'hA, 1);

    unclaimed("unc.f3", mk(3'b110));
    unclaimed("unc.op", {7'h01, 18'd0, 7'h33});
    op("unc.lo", 3'b011, 0, 0, 32'hA, 1);
    op("unc.hi", 3'b100, 0, 0, 32'h2, 1);

    // CPU abort of a MAC in cycle 5
    @(negedge clk);
    insn  = mk(3'b010);
    rs1   = 32'd100;
    rs2   = 32'd100;
    valid = 1'b1;
    repeat (5) @(negedge clk);
    valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (rdy !== 1'b0 || wt !== 1'b0) cnt++;
    end
    chk("abort.quiet", 64'(cnt), 64'd0);
    op("abort.lo", 3'b011, 0, 0, 32'hA, 1);
    op("abort.mul", 3'b000, 32'd7, 32'd6, 32'd42, MCYC);

    // valid held 3 cycles past ready
    @(negedge clk);
    insn  = mk(3'b000);
    rs1   = 32'h10;
    rs2   = 32'h10;
    valid = 1'b1;
    cnt = 0;
    rc  = -1;
    r   = '0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        cnt++;
        rc = k;
        r  = rd;
      end
      if (rc > 0 && k == rc + 3) valid = 1'b0;
    end
    valid = 1'b0;
    chk("hold.pulses", 64'(cnt), 64'd1);
    chk("hold.rd", 64'(r), 64'h100);

    // accumulator wraps modulo 2^64
    op("w.clr", 3'b101, 0, 0, 32'h0, 1);
    op("w.mac1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
       32'h1, MCYC);
    op("w.mac2", 3'b010, 32'hFFFF_FFFF, 32'd2,
       32'hFFFF_FFFF, MCYC);
    op("w.hi", 3'b100, 0, 0, 32'hFFFF_FFFF, 1);
    op("w.mac3", 3'b010, 32'd1, 32'd1, 32'h0, MCYC);
    op("w.hi0", 3'b100, 0, 0, 32'h0, 1);

    // async reset between edges mid-BUSY
    op("r.mac", 3'b010, 32'd3, 32'd4, 32'd12, MCYC);
    @(negedge clk);
    insn  = mk(3'b010);
    rs1   = 32'd5;
    rs2   = 32'd5;
    valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("r.busy", 64'(wt), 64'd1);
    #2 rst = 1'b1;
    #1 chk("r.async", {wt, rdy, wr, rd}, '0);
    @(negedge clk);
    valid = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    op("r.lo", 3'b011, 0, 0, 32'h0, 1);
    op("r.hi", 3'b100, 0, 0, 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
